// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite address generator and its animation sequencer.
package sprite_pkg;

    typedef enum logic {IDLE, PLAY} anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Beam/sprite position inputs and ROM address/animation outputs of sprite_addr_gen.
interface sprite_addr_gen_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int FW     = 2
);
    coord_t            draw_x;
    coord_t            draw_y;
    logic              vsync;
    coord_t            sprite_x;
    coord_t            sprite_y;
    logic              facing_left;
    logic              trigger;
    logic [ADDR_W-1:0] rom_address;
    logic              in_sprite;
    logic              in_sprite_px;
    logic [FW-1:0]     frame_idx;
    logic              busy;
    logic              done;

    modport master (
        output draw_x, draw_y, vsync, sprite_x, sprite_y, facing_left, trigger,
        input  rom_address, in_sprite, in_sprite_px, frame_idx, busy, done
    );

    modport slave (
        input  draw_x, draw_y, vsync, sprite_x, sprite_y, facing_left, trigger,
        output rom_address, in_sprite, in_sprite_px, frame_idx, busy, done
    );
endinterface

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: vsync fall detector, pending trigger, per-frame hold counter and frame index.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          i_trigger,
    output logic [FW-1:0] o_frame_idx,
    output logic          o_busy,
    output logic          o_done
);

    anim_state_t   r_state, w_state_next;
    logic          r_vsync_q;
    logic          r_pend, w_pend_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic [FW-1:0] r_frame, w_frame_next;
    logic          r_done, w_done_next;
    logic          w_vs_fall;

    assign w_vs_fall = r_vsync_q & ~i_vsync;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vsync_q <= 1'b1;
            r_pend    <= 1'b0;
            r_hold    <= '0;
            r_frame   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_vsync_q <= i_vsync;
            r_pend    <= w_pend_next;
            r_hold    <= w_hold_next;
            r_frame   <= w_frame_next;
            r_done    <= w_done_next;
        end
    end

    // Frame index only moves on a vsync fall, so a frame is never torn mid-screen.
    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_hold_next  = r_hold;
        w_frame_next = r_frame;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vs_fall && r_pend) begin
                    w_state_next = PLAY;
                    w_pend_next  = 1'b0;
                    w_hold_next  = '0;
                    w_frame_next = '0;
                end else if (i_trigger) begin
                    w_pend_next = 1'b1;
                end
            end
            PLAY: begin
                if (w_vs_fall) begin
                    if (r_hold == HW'(FRAME_HOLD - 1)) begin
                        w_hold_next = '0;
                        if (r_frame == FW'(NUM_FRAMES - 1)) begin
                            w_state_next = IDLE;
                            w_frame_next = '0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_frame_next = r_frame + 1'b1;
                        end
                    end else begin
                        w_hold_next = r_hold + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_frame_idx = r_frame;
    assign o_busy      = (r_state == PLAY);
    assign o_done      = r_done;

endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator with animation frames; define SPRITE_MIRROR_EN to enable facing_left mirroring.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 64,
    parameter int SPRITE_H   = 64,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 14,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic            vga_clk,
    input  logic            rst_n,
    sprite_addr_gen_if.slave bus
);

    localparam int FRAME_SZ = SPRITE_W * SPRITE_H;

    logic [FW-1:0]     w_frame_idx;
    logic              w_busy;
    logic              w_done;
    logic [10:0]       w_col, w_row, w_col_m;
    logic              w_in_x, w_in_y, w_in;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_in, r_in_px;

    sprite_anim_seq #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_seq (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .i_vsync     (bus.vsync),
        .i_trigger   (bus.trigger),
        .o_frame_idx (w_frame_idx),
        .o_busy      (w_busy),
        .o_done      (w_done)
    );

    // Box limits are compared at 11 bits so a sprite near the right/bottom edge cannot wrap.
    always_comb begin
        w_col  = {1'b0, bus.draw_x} - {1'b0, bus.sprite_x};
        w_row  = {1'b0, bus.draw_y} - {1'b0, bus.sprite_y};
        w_in_x = (bus.draw_x >= bus.sprite_x) &&
                 ({1'b0, bus.draw_x} < ({1'b0, bus.sprite_x} + 11'(SPRITE_W)));
        w_in_y = (bus.draw_y >= bus.sprite_y) &&
                 ({1'b0, bus.draw_y} < ({1'b0, bus.sprite_y} + 11'(SPRITE_H)));
        w_in   = w_in_x && w_in_y;
`ifdef SPRITE_MIRROR_EN
        w_col_m = bus.facing_left ? (11'(SPRITE_W - 1) - w_col) : w_col;
`else
        w_col_m = w_col;
`endif
        w_addr = '0;
        if (w_in) begin
            w_addr = ADDR_W'(32'(w_frame_idx) * 32'(FRAME_SZ) +
                             32'(w_row) * 32'(SPRITE_W) + 32'(w_col_m));
        end
    end

    // in_sprite_px trails by one more cycle to line up with the reader's registered RGB.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_in    <= 1'b0;
            r_in_px <= 1'b0;
        end else begin
            r_addr  <= w_addr;
            r_in    <= w_in;
            r_in_px <= r_in;
        end
    end

    assign bus.rom_address  = r_addr;
    assign bus.in_sprite    = r_in;
    assign bus.in_sprite_px = r_in_px;
    assign bus.frame_idx    = w_frame_idx;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed self-checking bench for sprite_addr_gen: address corners, mirroring, playback, retrigger, reset, alignment.
module tb_sprite_addr_gen;
    import sprite_pkg::*;

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   done_cnt = 0;

    sprite_addr_gen_if #(.ADDR_W(14), .FW(2)) bus ();

    sprite_addr_gen dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic vs_pulse();
        bus.vsync = 1'b0;
        cyc(); cyc();
        bus.vsync = 1'b1;
        cyc(); cyc();
    endtask

    task automatic start_anim();
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        vs_pulse();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        bus.draw_x = 10'd100; bus.draw_y = 10'd50;
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
        bus.vsync = 1'b1; bus.facing_left = 1'b0; bus.trigger = 1'b0;
        rst_n = 1'b0;
        cyc(); cyc();
        checks++;
        if (bus.rom_address !== 14'd0 || bus.in_sprite !== 1'b0 || bus.in_sprite_px !== 1'b0 ||
            bus.frame_idx !== 2'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d in=%b px=%b frame=%0d busy=%b done=%b, expected all zero",
                     bus.rom_address, bus.in_sprite, bus.in_sprite_px, bus.frame_idx, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        cyc();
        $display("test_reset complete");
    endtask

    task automatic test_addr_corners();
        int xs[5]    = '{100, 163, 164, 99, 120};
        int ys[5]    = '{50, 113, 50, 50, 60};
        int eaddr[5] = '{0, 4095, 0, 0, 660};
        bit ein[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
        for (int i = 0; i < 5; i++) begin
            bus.draw_x = 10'(xs[i]); bus.draw_y = 10'(ys[i]);
            cyc();
            checks++;
            if (bus.rom_address !== 14'(eaddr[i]) || bus.in_sprite !== ein[i]) begin
                errors++;
                $display("FAIL addr_corner(%0d,%0d): addr=%0d in=%b, expected addr=%0d in=%b",
                         xs[i], ys[i], bus.rom_address, bus.in_sprite, eaddr[i], ein[i]);
            end
        end
        $display("test_addr_corners complete");
    endtask

    task automatic test_mirror();
        logic [13:0] exp_addr;
`ifdef SPRITE_MIRROR_EN
        exp_addr = 14'd63;
`else
        exp_addr = 14'd0;
`endif
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
        bus.draw_x = 10'd100; bus.draw_y = 10'd50;
        bus.facing_left = 1'b1;
        cyc();
        checks++;
        if (bus.rom_address !== exp_addr || bus.in_sprite !== 1'b1) begin
            errors++;
            $display("FAIL mirror: addr=%0d in=%b, expected addr=%0d in=1", bus.rom_address, bus.in_sprite, exp_addr);
        end
        bus.facing_left = 1'b0;
        cyc();
        $display("test_mirror complete");
    endtask

    task automatic test_right_edge();
        bus.sprite_x = 10'd600; bus.sprite_y = 10'd50;
        bus.draw_x = 10'd20; bus.draw_y = 10'd50;
        cyc();
        checks++;
        if (bus.in_sprite !== 1'b0 || bus.rom_address !== 14'd0) begin
            errors++;
            $display("FAIL right_edge_wrap: in=%b addr=%0d, expected in=0 addr=0", bus.in_sprite, bus.rom_address);
        end
        bus.draw_x = 10'd630;
        cyc();
        checks++;
        if (bus.in_sprite !== 1'b1 || bus.rom_address !== 14'd30) begin
            errors++;
            $display("FAIL right_edge_inside: in=%b addr=%0d, expected in=1 addr=30", bus.in_sprite, bus.rom_address);
        end
        $display("test_right_edge complete");
    endtask

    task automatic test_playback();
        int exp_frame;
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
        bus.draw_x = 10'd100; bus.draw_y = 10'd50;
        done_cnt = 0;
        start_anim();
        checks++;
        if (bus.busy !== 1'b1 || bus.frame_idx !== 2'd0) begin
            errors++;
            $display("FAIL play_start: busy=%b frame=%0d, expected busy=1 frame=0", bus.busy, bus.frame_idx);
        end
        for (int k = 1; k <= 24; k++) begin
            vs_pulse();
            exp_frame = (k < 24) ? k / 6 : 0;
            checks++;
            if (bus.frame_idx !== 2'(exp_frame) || bus.busy !== (k < 24)) begin
                errors++;
                $display("FAIL play_edge%0d: frame=%0d busy=%b, expected frame=%0d busy=%b",
                         k, bus.frame_idx, bus.busy, exp_frame, (k < 24));
            end
            if (k == 12) begin
                checks++;
                if (bus.rom_address !== 14'd8192) begin
                    errors++;
                    $display("FAIL play_frame2_addr: addr=%0d, expected 8192", bus.rom_address);
                end
            end
            if (k == 23) begin
                checks++;
                if (done_cnt !== 0) begin
                    errors++;
                    $display("FAIL play_early_done: done cycles=%0d, expected 0", done_cnt);
                end
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL play_done_pulse: done cycles=%0d, expected 1", done_cnt);
        end
        $display("test_playback complete");
    endtask

    task automatic test_retrigger();
        done_cnt = 0;
        start_anim();
        for (int k = 1; k <= 24; k++) begin
            vs_pulse();
            if (k == 3) begin
                bus.trigger = 1'b1;
                cyc();
                bus.trigger = 1'b0;
            end
            if (k % 6 == 0) begin
                checks++;
                if (bus.frame_idx !== 2'((k < 24) ? k / 6 : 0)) begin
                    errors++;
                    $display("FAIL retrig_edge%0d: frame=%0d, expected %0d", k, bus.frame_idx, (k < 24) ? k / 6 : 0);
                end
            end
        end
        vs_pulse(); vs_pulse();
        checks++;
        if (bus.busy !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL retrig_ignored: busy=%b done cycles=%0d, expected busy=0 done=1", bus.busy, done_cnt);
        end
        $display("test_retrigger complete");
    endtask

    task automatic test_reset_mid();
        done_cnt = 0;
        bus.draw_x = 10'd100; bus.draw_y = 10'd50;
        start_anim();
        repeat (12) vs_pulse();
        checks++;
        if (bus.frame_idx !== 2'd2 || bus.rom_address !== 14'd8192) begin
            errors++;
            $display("FAIL rstmid_pre: frame=%0d addr=%0d, expected frame=2 addr=8192", bus.frame_idx, bus.rom_address);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.frame_idx !== 2'd0 || bus.busy !== 1'b0 || bus.rom_address !== 14'd0) begin
            errors++;
            $display("FAIL rstmid_async: frame=%0d busy=%b addr=%0d, expected 0/0/0",
                     bus.frame_idx, bus.busy, bus.rom_address);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        vs_pulse();
        checks++;
        if (done_cnt !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: done cycles=%0d busy=%b, expected 0/0", done_cnt, bus.busy);
        end
        $display("test_reset_mid complete");
    endtask

    task automatic test_trig_vsfall();
        bus.trigger = 1'b1;
        bus.vsync = 1'b0;
        cyc();
        bus.trigger = 1'b0;
        cyc();
        bus.vsync = 1'b1;
        cyc(); cyc();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL trig_vsfall_same: busy=%b, expected 0", bus.busy);
        end
        vs_pulse();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_vsfall_next: busy=%b, expected 1", bus.busy);
        end
        do_reset();
        $display("test_trig_vsfall complete");
    endtask

    task automatic test_alignment();
        bit exp_now, exp_prev;
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
        bus.draw_y = 10'd50; bus.draw_x = 10'd0;
        cyc(); cyc();
        exp_prev = 1'b0;
        for (int x = 1; x < SCREEN_W; x++) begin
            bus.draw_x = 10'(x);
            cyc();
            exp_now = (x >= 100) && (x < 164);
            checks++;
            if (bus.in_sprite !== exp_now || bus.in_sprite_px !== exp_prev) begin
                errors++;
                $display("FAIL align_x%0d: in=%b px=%b, expected in=%b px=%b",
                         x, bus.in_sprite, bus.in_sprite_px, exp_now, exp_prev);
            end
            exp_prev = exp_now;
        end
        $display("test_alignment complete");
    endtask

    initial begin
        test_reset();
        test_addr_corners();
        test_mirror();
        test_right_edge();
        test_playback();
        test_retrigger();
        test_reset_mid();
        test_trig_vsfall();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
